// File: rtl/base_ram_arbiter_pkg.sv
// Shared encodings for the BaseRAM arbiter: FSM states, access owner and the
// values the SRAM pins rest at when no access is in flight.
package base_ram_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_WR_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic       IDLE_CE_N = 1'b1;
  localparam logic       IDLE_OE_N = 1'b1;
  localparam logic       IDLE_WE_N = 1'b1;
  localparam logic [3:0] IDLE_BE_N = 4'hF;

  // Chip select is asserted only while the SRAM is actually being accessed.
  function automatic logic pins_active(input logic [2:0] st);
    return (st == ST_RD) || (st == ST_WR) || (st == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/base_ram_arbiter_arb_prio_guard.sv
// Grant decision for the IDLE state: LSU has priority, but after LSU_STREAK
// consecutive LSU grants with the IFU waiting, the IFU is forced through.
module arb_prio_guard #(
  parameter int LSU_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  input  logic ifu_req_i,
  input  logic lsu_req_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);

  localparam logic [3:0] STREAK_MAX = 4'(LSU_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       ifu_forced;

  always_comb begin
    ifu_forced  = ifu_req_i && (streak_q >= STREAK_MAX);
    grant_lsu_o = sample_i && lsu_req_i && !ifu_forced;
    grant_ifu_o = sample_i && ifu_req_i && !grant_lsu_o;

    streak_d = streak_q;
    if (grant_ifu_o) begin
      streak_d = 4'd0;
    end else if (grant_lsu_o) begin
      if (!ifu_req_i)
        streak_d = 4'd0;
      else if (streak_q != 4'hF)
        streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= 4'd0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/base_ram_arbiter.sv
// Registered arbiter sharing the single BaseRAM port between instruction fetch
// and load/store, with multi-cycle SRAM read/write timing.
module base_ram_arbiter
  import base_ram_arbiter_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int LSU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_resp_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_n_i,
  input  logic [3:0]  lsu_be_n_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_o,
  output logic [31:0] base_ram_wdata,
  input  logic [31:0] base_ram_rdata,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n
);

  localparam logic [2:0] RD_LOAD = 3'(READ_WAIT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WRITE_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  be_n_q, be_n_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic        ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;
  logic        grant_ifu, grant_lsu;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{ifu_addr_i[31:22], ifu_addr_i[1:0],
                              lsu_addr_i[31:22], lsu_addr_i[1:0]};

  arb_prio_guard #(.LSU_STREAK(LSU_STREAK)) u_guard (
    .clk         (clk),
    .rst         (rst),
    .sample_i    (state_q == ST_IDLE),
    .ifu_req_i   (ifu_req_i),
    .lsu_req_i   (lsu_req_i),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_n_d      = be_n_q;
    wdata_d     = wdata_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_addr_i[21:2];
          wdata_d = lsu_wdata_i;
          if (lsu_we_n_i) begin
            state_d = ST_RD;
            cnt_d   = RD_LOAD;
            be_n_d  = 4'b0000;
          end else begin
            state_d = ST_WR;
            cnt_d   = WR_LOAD;
            be_n_d  = lsu_be_n_i;
          end
        end else if (grant_ifu) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_addr_i[21:2];
          be_n_d  = 4'b0000;
          state_d = ST_RD;
          cnt_d   = RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          be_n_d  = IDLE_BE_N;
          if (owner_q == OWN_LSU) lsu_rdata_d = base_ram_rdata;
          else                    ifu_rdata_d = base_ram_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR: begin
        if (cnt_q == 3'd0) state_d = ST_WR_HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_WR_HOLD: begin
        state_d = ST_DONE;
        be_n_d  = IDLE_BE_N;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pins and responses are decoded from the next state so they leave the flops aligned with it.
    ce_n_d     = !pins_active(state_d);
    oe_n_d     = (state_d != ST_RD);
    we_n_d     = (state_d != ST_WR);
    ifu_resp_d = (state_d == ST_DONE) && (owner_d == OWN_IFU);
    lsu_resp_d = (state_d == ST_DONE) && (owner_d == OWN_LSU);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= 3'd0;
      addr_q      <= 20'd0;
      be_n_q      <= IDLE_BE_N;
      wdata_q     <= 32'd0;
      ce_n_q      <= IDLE_CE_N;
      oe_n_q      <= IDLE_OE_N;
      we_n_q      <= IDLE_WE_N;
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      be_n_q      <= be_n_d;
      wdata_q     <= wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
    end
  end

  assign base_ram_addr  = addr_q;
  assign base_ram_be_n  = be_n_q;
  assign base_ram_wdata = wdata_q;
  assign base_ram_ce_n  = ce_n_q;
  assign base_ram_oe_n  = oe_n_q;
  assign base_ram_we_n  = we_n_q;
  assign ifu_rdata_o    = ifu_rdata_q;
  assign lsu_rdata_o    = lsu_rdata_q;
  assign ifu_resp_o     = ifu_resp_q;
  assign lsu_resp_o     = lsu_resp_q;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: behavioural SRAM model, directed requests, and a
// response scoreboard checked by an independent monitor.
module tb_base_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, lsu_req, lsu_we_n;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [3:0]  lsu_be_n;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        ifu_resp, lsu_resp;
  logic [31:0] ram_wdata, ram_rdata;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  base_ram_arbiter #(.READ_WAIT(2), .WRITE_WAIT(2), .LSU_STREAK(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_i      (ifu_req),
    .ifu_addr_i     (ifu_addr),
    .ifu_rdata_o    (ifu_rdata),
    .ifu_resp_o     (ifu_resp),
    .lsu_req_i      (lsu_req),
    .lsu_we_n_i     (lsu_we_n),
    .lsu_be_n_i     (lsu_be_n),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_rdata_o    (lsu_rdata),
    .lsu_resp_o     (lsu_resp),
    .base_ram_wdata (ram_wdata),
    .base_ram_rdata (ram_rdata),
    .base_ram_addr  (ram_addr),
    .base_ram_be_n  (ram_be_n),
    .base_ram_ce_n  (ram_ce_n),
    .base_ram_oe_n  (ram_oe_n),
    .base_ram_we_n  (ram_we_n)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[5:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) mem[ram_addr[5:0]][8*b +: 8] = ram_wdata[8*b +: 8];
  end

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   ifu_cyc, lsu_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (ifu_resp || lsu_resp) begin
      chk("resp_exclusive", 32'(ifu_resp & lsu_resp), 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_unexpected: ifu_resp=%b lsu_resp=%b with nothing pending", ifu_resp, lsu_resp);
      end else begin
        e = exp_q.pop_front();
        chk("resp_owner_is_lsu", 32'(lsu_resp), 32'(e.lsu));
        chk("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.data);
      end
    end
  end

  // Hold requests until n_lsu / n_ifu responses have been seen, dropping each on its last resp.
  task automatic serve(input int n_lsu, input int n_ifu);
    int nl = 0;
    int ni = 0;
    int k  = 0;
    while ((nl < n_lsu || ni < n_ifu) && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (lsu_resp) begin
        nl++;
        lsu_cyc = cyc;
        if (nl >= n_lsu) lsu_req = 1'b0;
      end
      if (ifu_resp) begin
        ni++;
        ifu_cyc = cyc;
        if (ni >= n_ifu) ifu_req = 1'b0;
      end
    end
    if (k >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL serve_timeout: lsu %0d/%0d ifu %0d/%0d responses", nl, n_lsu, ni, n_ifu);
      lsu_req = 1'b0;
      ifu_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_cnt, resp_cnt;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
    mem[4] = 32'h1234_5678;
    mem[8] = 32'h1122_3344;
    rst = 1'b1;
    ifu_req = 1'b0; lsu_req = 1'b0; lsu_we_n = 1'b1; lsu_be_n = 4'b0000;
    ifu_addr = 32'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;

    @(negedge clk); @(negedge clk);
    chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_be_n", 32'(ram_be_n), 32'hF);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
    chk("rst_resp", 32'({ifu_resp, lsu_resp}), 32'd0);
    rst = 1'b0;

    // IFU read of word 4
    @(negedge clk);
    ifu_addr = 32'h8000_0010; ifu_req = 1'b1;
    exp_q.push_back('{1'b0, 32'h1234_5678});
    @(posedge clk); #1;
    chk("rd_ce_n", 32'(ram_ce_n), 32'd0);
    chk("rd_oe_n_c1", 32'(ram_oe_n), 32'd0);
    chk("rd_we_n", 32'(ram_we_n), 32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h4);
    chk("rd_be_n", 32'(ram_be_n), 32'h0);
    @(posedge clk); #1;
    chk("rd_oe_n_c2", 32'(ram_oe_n), 32'd0);
    chk("rd_no_early_resp", 32'(ifu_resp), 32'd0);
    @(posedge clk); #1;
    chk("rd_resp_t3", 32'(ifu_resp), 32'd1);
    chk("rd_done_pins", 32'({ram_ce_n, ram_oe_n}), 32'h3);
    ifu_req = 1'b0;
    repeat (2) @(posedge clk);

    // LSU partial write to word 8
    @(negedge clk);
    lsu_addr = 32'h8000_0020; lsu_we_n = 1'b0; lsu_be_n = 4'b1100;
    lsu_wdata = 32'hAABB_CCDD; lsu_req = 1'b1;
    exp_q.push_back('{1'b1, 32'h0000_0000});
    @(posedge clk); #1;
    chk("wr_we_n_c1", 32'(ram_we_n), 32'd0);
    chk("wr_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'h1);
    chk("wr_addr", 32'(ram_addr), 32'h8);
    chk("wr_be_n", 32'(ram_be_n), 32'hC);
    chk("wr_wdata", ram_wdata, 32'hAABB_CCDD);
    @(posedge clk); #1;
    chk("wr_we_n_c2", 32'(ram_we_n), 32'd0);
    @(posedge clk); #1;
    chk("wr_hold_we_n", 32'(ram_we_n), 32'd1);
    chk("wr_hold_ce_n", 32'(ram_ce_n), 32'd0);
    chk("wr_hold_no_resp", 32'(lsu_resp), 32'd0);
    @(posedge clk); #1;
    chk("wr_resp_t4", 32'(lsu_resp), 32'd1);
    chk("wr_mem_bytes", mem[8], 32'h1122_CCDD);
    lsu_req = 1'b0; lsu_we_n = 1'b1; lsu_be_n = 4'b0000;
    repeat (2) @(posedge clk);

    // Simultaneous requests: LSU first, IFU after DONE + IDLE + 2 RD cycles
    @(negedge clk);
    lsu_addr = 32'h8000_0020; ifu_addr = 32'h8000_0010;
    lsu_req = 1'b1; ifu_req = 1'b1;
    exp_q.push_back('{1'b1, 32'h1122_CCDD});
    exp_q.push_back('{1'b0, 32'h1234_5678});
    serve(1, 1);
    chk("simul_ifu_gap", 32'(ifu_cyc - lsu_cyc), 32'd4);
    repeat (2) @(posedge clk);

    // Starvation guard: LSU held, IFU waiting -> 4 LSU, 1 IFU, then LSU again
    @(negedge clk);
    lsu_req = 1'b1; ifu_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'h1122_CCDD});
    exp_q.push_back('{1'b0, 32'h1234_5678});
    exp_q.push_back('{1'b1, 32'h1122_CCDD});
    serve(5, 1);
    repeat (2) @(posedge clk);

    // Request dropped during RD: one resp, no second access
    @(negedge clk);
    ifu_addr = 32'h8000_0010; ifu_req = 1'b1;
    exp_q.push_back('{1'b0, 32'h1234_5678});
    @(posedge clk); #1;
    ifu_req = 1'b0;
    ce_cnt = (ram_ce_n == 1'b0) ? 1 : 0;
    resp_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (!ram_ce_n) ce_cnt++;
      if (ifu_resp) resp_cnt++;
    end
    chk("drop_ce_cycles", 32'(ce_cnt), 32'd2);
    chk("drop_resp_count", 32'(resp_cnt), 32'd1);

    // Async reset in the middle of a write
    @(negedge clk);
    lsu_addr = 32'h8000_0030; lsu_we_n = 1'b0; lsu_be_n = 4'b0000;
    lsu_wdata = 32'hCAFE_F00D; lsu_req = 1'b1;
    @(posedge clk); #1;
    chk("arst_we_n_before", 32'(ram_we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_we_n_now", 32'(ram_we_n), 32'd1);
    chk("arst_ce_n_now", 32'(ram_ce_n), 32'd1);
    lsu_req = 1'b0; lsu_we_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ce_cnt = 0;
    resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (!ram_ce_n) ce_cnt++;
      if (ifu_resp || lsu_resp) resp_cnt++;
    end
    chk("arst_idle_ce", 32'(ce_cnt), 32'd0);
    chk("arst_no_resp", 32'(resp_cnt), 32'd0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
